// File: rtl/booth_seq_controller_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier controller:
// state encoding, adder operation encodings and datapath widths.
package booth_seq_controller_pkg;

    localparam int WIDTH = 8;   // operand width, matches the adder/subtractor
    localparam int CNT_W = 4;   // iteration counter width, $clog2(WIDTH)+1

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/booth_seq_controller.sv
// Sequential radix-2 Booth multiplier: control FSM plus the A/Q/Q_1/M
// register file. One add/sub/no-op through the external shared adder per
// CALC cycle, then an arithmetic right shift of {A,Q,Q_1}.
module booth_seq_controller
    import booth_seq_controller_pkg::*;
#(
    parameter int WIDTH = booth_seq_controller_pkg::WIDTH,
    parameter int CNT_W = booth_seq_controller_pkg::CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               as_cin,
    output logic [WIDTH-1:0]   as_i0,
    output logic [WIDTH-1:0]   as_i1,
    input  logic [WIDTH-1:0]   as_sum
);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   a_reg, q_reg, m_reg;
    logic               q_1;
    logic [CNT_W-1:0]   count;

    logic               op_active;
    logic [WIDTH-1:0]   a_new;
    logic               ovf;
    logic               shift_in;
    logic [WIDTH-1:0]   a_nxt, q_nxt;
    logic               last_iter;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start)     state_nxt = S_CALC;
            S_CALC: if (last_iter) state_nxt = S_DONE;
            S_DONE:                state_nxt = S_IDLE;
            default:               state_nxt = S_IDLE;
        endcase
    end

    // Booth step: decode {Q[0],Q_1}, pick the adder result or hold A, then
    // form the shifted values. The shift-in bit is the true sign of the
    // 9-bit add/sub result, which keeps M=-128 exact.
    always_comb begin
        last_iter = (state == S_CALC) && (count == CNT_W'(1));
        op_active = (state == S_CALC) && (q_reg[0] ^ q_1);
        as_cin    = (state == S_CALC && q_reg[0] && !q_1) ? OP_SUB : OP_ADD;
        a_new     = op_active ? as_sum : a_reg;
        ovf       = op_active && (a_reg[WIDTH-1] == (m_reg[WIDTH-1] ^ as_cin))
                              && (as_sum[WIDTH-1] != a_reg[WIDTH-1]);
        shift_in  = a_new[WIDTH-1] ^ ovf;
        a_nxt     = {shift_in, a_new[WIDTH-1:1]};
        q_nxt     = {a_new[0], q_reg[WIDTH-1:1]};
    end

    // Operand load on accepted start, iteration in CALC, product capture on
    // the final iteration so it is valid alongside done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg   <= '0;
            q_reg   <= '0;
            q_1     <= 1'b0;
            m_reg   <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    m_reg <= multiplicand;
                    q_reg <= multiplier;
                    a_reg <= '0;
                    q_1   <= 1'b0;
                    count <= CNT_W'(WIDTH);
                end
                S_CALC: begin
                    a_reg <= a_nxt;
                    q_reg <= q_nxt;
                    q_1   <= q_reg[0];
                    count <= count - CNT_W'(1);
                    if (last_iter) product <= {a_nxt, q_nxt};
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state != S_IDLE);
    assign done  = (state == S_DONE);
    assign as_i0 = a_reg;
    assign as_i1 = m_reg;

endmodule

// File: tb/tb_booth_seq_controller.sv
// Self-checking bench for booth_seq_controller with an ideal behavioural
// adder/subtractor and a transaction-level reference model.
module tb_booth_seq_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  multiplicand = '0;
    logic [7:0]  multiplier = '0;
    logic        busy, done, as_cin;
    logic [15:0] product;
    logic [7:0]  as_i0, as_i1, as_sum;

    int tests = 0;
    int fails = 0;

    booth_seq_controller dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .busy(busy), .done(done), .product(product),
        .as_cin(as_cin), .as_i0(as_i0), .as_i1(as_i1), .as_sum(as_sum)
    );

    // External adder/subtractor: i0 + i1 or i0 - i1, same cycle
    assign as_sum = as_cin ? (as_i0 - as_i1) : (as_i0 + as_i1);

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a start seen while idle begins a 9-cycle busy window,
    // with the signed product appearing in the last cycle of that window.
    int          rem = 0;
    logic [15:0] pend = '0;
    logic [15:0] held = '0;
    int          m_dones = 0;
    int          d_dones = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem  = 0;
            held = '0;
        end else if (rem == 0) begin
            if (start) begin
                int p;
                p    = int'($signed(multiplicand)) * int'($signed(multiplier));
                pend = p[15:0];
                rem  = 9;
            end
        end else begin
            rem--;
            if (rem == 1) begin
                held = pend;
                m_dones++;
            end
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(rem > 0));
        chk("done", 32'(done), 32'(rem == 1));
        chk("product", 32'(product), 32'(held));
        if (done) d_dones++;
    end

    task automatic do_mul(input logic [7:0] m, input logic [7:0] q,
                          input logic [15:0] exp, input string name);
        int n;
        @(negedge clk);
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_latency"}, 32'(n), 32'd9);
        chk(name, 32'(product), 32'(exp));
    endtask

    initial begin
        int n, dcnt;
        repeat (2) @(negedge clk);
        // Reset state
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_product", 32'(product), 32'd0);
        chk("rst_as_i0", 32'(as_i0), 32'd0);
        chk("rst_as_i1", 32'(as_i1), 32'd0);
        chk("rst_as_cin", 32'(as_cin), 32'd0);
        #1 rst_n = 1'b1;

        // Directed products
        do_mul(8'd3,   8'd5,   16'h000F, "3x5");
        do_mul(8'hFD,  8'd5,   16'hFFF1, "m3x5");
        do_mul(8'd5,   8'hFD,  16'hFFF1, "5xm3");
        do_mul(8'h80,  8'h80,  16'h4000, "m128xm128");
        do_mul(8'h7F,  8'h80,  16'hC080, "127xm128");
        do_mul(8'h80,  8'h7F,  16'hC080, "m128x127");
        do_mul(8'h00,  8'hFF,  16'h0000, "0xm1");

        // Start while busy is ignored
        @(negedge clk);
        multiplicand = 8'd3; multiplier = 8'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        multiplicand = 8'hFF; multiplier = 8'h80; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dcnt = 0;
        repeat (14) begin
            @(negedge clk);
            if (done) begin
                dcnt++;
                chk("busy_ignore_product", 32'(product), 32'h000F);
            end
        end
        chk("busy_ignore_dones", 32'(dcnt), 32'd1);

        // Reset mid-CALC
        @(negedge clk);
        multiplicand = 8'd9; multiplier = 8'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_product", 32'(product), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        dcnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("abort_no_done", 32'(dcnt), 32'd0);
        do_mul(8'd7, 8'd7, 16'h0031, "7x7");

        // Back-to-back random starts with operands changing every cycle
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            multiplicand = 8'($urandom);
            multiplier   = 8'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drain_idle", 32'(busy), 32'd0);
        chk("done_count", 32'(d_dones), 32'(m_dones));
        chk("sweep_size", 32'(m_dones > 400), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
